// File: rtl/fc_backward.sv
// Transposed fully connected layer: grad_out[j] = sum_i weight[i][j] * grad_in[i],
// computed one signed product per cycle through a single time-multiplexed MAC.
module fc_backward #(
  parameter int BITWIDTH    = 8,
  parameter int INPUT_SIZE  = 7,
  parameter int OUTPUT_SIZE = 5
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [BITWIDTH*OUTPUT_SIZE-1:0]            grad_in,
  input  logic [BITWIDTH*INPUT_SIZE*OUTPUT_SIZE-1:0] weight,
  output logic                                      busy,
  output logic                                      done,
  output logic [2*BITWIDTH*INPUT_SIZE-1:0]           grad_out
);

  localparam int OW    = 2 * BITWIDTH;
  localparam int ACC_W = OW + $clog2(OUTPUT_SIZE);
  localparam int IW    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int JW    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(OUTPUT_SIZE - 1);
  localparam logic [JW-1:0] J_LAST = JW'(INPUT_SIZE - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nxt;
  logic   done_p1;
  logic   accept, last_i, last_j;

  logic [BITWIDTH*OUTPUT_SIZE-1:0]            g_r;
  logic [BITWIDTH*INPUT_SIZE*OUTPUT_SIZE-1:0] w_r;
  logic [IW-1:0]                              i;
  logic [JW-1:0]                              j;
  logic signed [ACC_W-1:0]                    acc, sum;
  logic signed [OW-1:0]                       prod;
  logic signed [BITWIDTH-1:0]                 w_sel, g_sel;

  function automatic logic signed [OW-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)
      return {1'b0, {(OW-1){1'b1}}};
    else if (v < SAT_MIN)
      return {1'b1, {(OW-1){1'b0}}};
    else
      return v[OW-1:0];
  endfunction

  // done is registered one cycle past the DONE state; busy spans that cycle too,
  // so a start is not accepted until the done pulse has been seen.
  always_comb begin
    accept    = (state == IDLE) && !done_p1 && start;
    last_i    = (i == I_LAST);
    last_j    = (j == J_LAST);
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (last_i && last_j) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_p1 <= (state == DONE);
    end
  end

  assign busy = (state != IDLE) || done_p1;
  assign done = done_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      g_r <= grad_in;
      w_r <= weight;
    end
  end

  // Operand select and MAC for the current (i, j)
  always_comb begin
    w_sel = w_r[(int'(i) * INPUT_SIZE + int'(j)) * BITWIDTH +: BITWIDTH];
    g_sel = g_r[int'(i) * BITWIDTH +: BITWIDTH];
    prod  = OW'(w_sel) * OW'(g_sel);
    sum   = acc + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= '0;
      j        <= '0;
      acc      <= '0;
      grad_out <= '0;
    end else if (accept) begin
      i   <= '0;
      j   <= '0;
      acc <= '0;
    end else if (state == MAC) begin
      if (!last_i) begin
        acc <= sum;
        i   <= i + 1'b1;
      end else begin
        grad_out[int'(j) * OW +: OW] <= sat(sum);
        acc <= '0;
        i   <= '0;
        if (!last_j) j <= j + 1'b1;
      end
    end
  end

endmodule
